// File: rtl/audio_tone_sequencer.sv
// Queued tone sequencer: tone requests go through a small FIFO and play back-to-back as square
// waves with a silent gap after each note. The sample feeds a one-bit-delayed I2S mono DAC stream.
module audio_tone_sequencer #(
  parameter int DIV_W      = 22,
  parameter int DUR_W      = 29,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int SAMPLE_W   = 16,
  parameter int LRCK_LOG2  = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DIV_W-1:0]    req_div,
  input  logic [DUR_W-1:0]    req_dur,
  input  logic [2:0]          req_vol,
  input  logic                flush,
  output logic                busy,
  output logic                note_done,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_sck,
  output logic                audio_sdin
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int SLOT_W = LRCK_LOG2 - 4;
  localparam int IDX_W  = $clog2(SAMPLE_W);
  localparam logic [GAP_W-1:0]     GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [SAMPLE_W-1:0]  AMP_MAX  = {2'b01, {(SAMPLE_W-2){1'b0}}};
  localparam logic [LRCK_LOG2-1:0] LATCH_AT = {1'b0, {(LRCK_LOG2-1){1'b1}}};

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DUR_W-1:0] dur;
    logic [2:0]       vol;
  } tone_req_t;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  tone_req_t          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  state_t             state, state_nxt;
  tone_req_t          cur, cur_nxt;
  logic [DUR_W-1:0]   tone_cnt, tone_nxt, dur_last;
  logic [DIV_W-1:0]   phase_cnt, phase_nxt;
  logic               wave_lvl, wave_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic               done_nxt;
  logic [SAMPLE_W-1:0] amp, sample_nxt;

  logic [LRCK_LOG2-1:0] sc;
  logic [SAMPLE_W-1:0]  word;
  logic [SLOT_W-1:0]    slot;
  logic [IDX_W-1:0]     bit_idx;

  // ready comes from the registered count only: a full FIFO stays not-ready during a pop
  assign req_ready = (count < CNT_W'(FIFO_DEPTH)) & ~flush;
  assign push      = req_valid & req_ready;
  assign busy      = (state != IDLE) | (count != '0);
  assign dur_last  = (cur.dur == '0) ? '0 : cur.dur - DUR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_div, req_dur, req_vol};
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    tone_nxt  = tone_cnt;
    phase_nxt = phase_cnt;
    wave_nxt  = wave_lvl;
    gap_nxt   = gap_cnt;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      tone_nxt  = '0;
      phase_nxt = '0;
      wave_nxt  = 1'b0;
      gap_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            pop       = 1'b1;
            cur_nxt   = fifo_mem[rd_ptr];
            tone_nxt  = '0;
            phase_nxt = '0;
            wave_nxt  = 1'b0;
            state_nxt = TONE;
          end
        end
        TONE: begin
          tone_nxt = tone_cnt + DUR_W'(1);
          if (phase_cnt == cur.div) begin
            phase_nxt = '0;
            wave_nxt  = ~wave_lvl;
          end else begin
            phase_nxt = phase_cnt + DIV_W'(1);
          end
          if (tone_cnt == dur_last) begin
            done_nxt  = 1'b1;
            tone_nxt  = '0;
            gap_nxt   = '0;
            state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            gap_nxt = gap_cnt + GAP_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // sample is built from next-cycle values so the register lines up with the FSM state
  always_comb begin
    amp        = AMP_MAX >> (3'd7 - cur_nxt.vol);
    sample_nxt = '0;
    if (state_nxt == TONE && cur_nxt.vol != 3'd0 && cur_nxt.div != '0)
      sample_nxt = wave_nxt ? amp : SAMPLE_W'(0) - amp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= '0;
      tone_cnt   <= '0;
      phase_cnt  <= '0;
      wave_lvl   <= 1'b0;
      gap_cnt    <= '0;
      note_done  <= 1'b0;
      sample_out <= '0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      tone_cnt   <= tone_nxt;
      phase_cnt  <= phase_nxt;
      wave_lvl   <= wave_nxt;
      gap_cnt    <= gap_nxt;
      note_done  <= done_nxt;
      sample_out <= sample_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc   <= '0;
      word <= '0;
    end else begin
      sc <= sc + LRCK_LOG2'(1);
      if (sc == LATCH_AT) word <= sample_out;
    end
  end

  assign audio_mclk = sc[1];
  assign audio_lrck = sc[LRCK_LOG2-1];
  assign audio_sck  = 1'b1;
  assign slot       = sc[LRCK_LOG2-1:4];

  // 2*SAMPLE_W slots per frame, so both SAMPLE_W-slot and 2*SAMPLE_W-slot reduce to -slot mod SAMPLE_W
  assign bit_idx    = IDX_W'(SLOT_W'(0) - slot);
  assign audio_sdin = (slot == '0) ? word[0] : word[bit_idx];

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Directed bench for audio_tone_sequencer with a 5-cycle gap and the default 16-bit I2S framing.
`timescale 1ns/1ps
module tb_audio_tone_sequencer;
  localparam int DIV_W = 22;
  localparam int DUR_W = 29;
  localparam int GAP   = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, flush = 1'b0;
  logic [DIV_W-1:0] req_div = '0;
  logic [DUR_W-1:0] req_dur = '0;
  logic [2:0]       req_vol = '0;
  logic busy, note_done, audio_mclk, audio_lrck, audio_sck, audio_sdin;
  logic [15:0] sample_out;

  audio_tone_sequencer #(.DIV_W(DIV_W), .DUR_W(DUR_W), .FIFO_DEPTH(4), .GAP_CYCLES(GAP),
                         .SAMPLE_W(16), .LRCK_LOG2(9)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_div(req_div), .req_dur(req_dur), .req_vol(req_vol), .flush(flush),
    .busy(busy), .note_done(note_done), .sample_out(sample_out),
    .audio_mclk(audio_mclk), .audio_lrck(audio_lrck), .audio_sck(audio_sck),
    .audio_sdin(audio_sdin));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nd_cnt = 0;
  int nd_stamp [64];
  always @(negedge clk) if (note_done) begin
    if (nd_cnt < 64) nd_stamp[nd_cnt] = cyc;
    nd_cnt = nd_cnt + 1;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // call just after a posedge; returns just after the accepting posedge
  task automatic push_one(input logic [DIV_W-1:0] d, input logic [DUR_W-1:0] u, input logic [2:0] v);
    logic r, ok;
    ok = 1'b0;
    req_div = d; req_dur = u; req_vol = v; req_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk); r = req_ready;
      @(posedge clk); if (r) ok = 1'b1;
    end
    #1 req_valid = 1'b0;
    if (!ok) chk("push accepted", 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < 3000) begin @(negedge clk); i++; end
    chk({tag, " idle"}, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic lrck_interval(output int c);
    logic l;
    l = audio_lrck; c = 0;
    do begin @(negedge clk); c++; end while (audio_lrck == l && c < 600);
  endtask

  task automatic wait_lrck(input logic v);
    int i;
    i = 0;
    while (audio_lrck !== v && i < 1000) begin @(negedge clk); i++; end
    if (i >= 1000) chk("lrck level reached", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int c, nz, base, mc;
    logic [15:0] es, left;
    logic [14:0] right;
    logic en, eb, found, prev_mclk;
    logic bits [0:32];

    // reset state
    #3;
    chk("rst req_ready", req_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst sample", sample_out, 0);
    chk("rst note_done", note_done, 0);
    chk("rst sdin", audio_sdin, 0);
    chk("rst lrck", audio_lrck, 0);
    chk("rst sck", audio_sck, 1);
    #20 rst_n = 1'b1;

    @(negedge clk);
    lrck_interval(c);
    lrck_interval(c);
    chk("lrck half period a", c, 256);
    lrck_interval(c);
    chk("lrck half period b", c, 256);
    mc = 0; prev_mclk = audio_mclk;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (audio_mclk != prev_mclk) mc++;
      prev_mclk = audio_mclk;
    end
    chk("mclk toggles in 16", mc, 8);
    @(posedge clk); #1;

    // single note: div 3, dur 20, vol 7
    base = nd_cnt;
    push_one(22'd3, 29'd20, 3'd7);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      es = (k >= 2 && k <= 21) ? ((((k - 2) / 4) % 2 == 0) ? 16'hC000 : 16'h4000) : 16'h0000;
      en = (k == 22);
      eb = (k <= 26);
      chk($sformatf("note1 sample k=%0d", k), sample_out, es);
      chk($sformatf("note1 done k=%0d", k), note_done, en);
      chk($sformatf("note1 busy k=%0d", k), busy, eb);
    end
    chk("note1 pulses", nd_cnt - base, 1);
    @(posedge clk); #1;

    // dur 0 plays as a single cycle
    push_one(22'd1, 29'd0, 3'd7);
    @(negedge clk);
    @(negedge clk); chk("dur0 tone sample", sample_out, 16'hC000); chk("dur0 no done yet", note_done, 0);
    @(negedge clk); chk("dur0 gap sample", sample_out, 16'h0000); chk("dur0 done", note_done, 1);
    @(negedge clk); chk("dur0 done single", note_done, 0);
    wait_idle("dur0");

    // FIFO fill while a filler note plays; vol 3 amplitude 1024
    base = nd_cnt;
    push_one(22'd1, 29'd30, 3'd3);
    @(negedge clk);
    @(negedge clk); chk("vol3 low", sample_out, 16'hFC00);
    @(negedge clk);
    @(negedge clk); chk("vol3 high", sample_out, 16'h0400);
    @(posedge clk); #1;
    begin
      int acc, budget;
      logic r, stalled;
      acc = 0; budget = 0; stalled = 1'b0;
      while (acc < 5 && budget < 400) begin
        req_valid = 1'b1; req_div = 22'd1; req_dur = 29'(3 + acc); req_vol = 3'd1;
        @(negedge clk); r = req_ready;
        if (acc == 4 && !r && !stalled) begin
          stalled = 1'b1;
          chk("fill stall no pop yet", nd_cnt - base, 0);
          chk("fill stall busy", busy, 1);
        end
        @(posedge clk);
        if (r) begin
          acc++;
          if (acc == 5) chk("fifth after filler done", nd_cnt - base, 1);
        end
        budget++;
        #1;
      end
      req_valid = 1'b0;
      chk("fill accepted", acc, 5);
      chk("fill stalled", stalled, 1);
    end
    c = 0;
    while (nd_cnt - base < 6 && c < 600) begin @(negedge clk); c++; end
    chk("fill pulses", nd_cnt - base, 6);
    for (int i = 1; i <= 5; i++)
      chk($sformatf("fill spacing %0d", i), nd_stamp[base + i] - nd_stamp[base + i - 1], 6 + 2 + i);
    wait_idle("fill");

    // rest (div 0) and mute (vol 0) stay silent but still complete
    base = nd_cnt;
    push_one(22'd0, 29'd10, 3'd7);
    push_one(22'd2, 29'd10, 3'd0);
    nz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_out != 16'h0000) nz++;
    end
    chk("silent samples", nz, 0);
    @(posedge clk); #1;
    wait_idle("silent");
    chk("silent pulses", nd_cnt - base, 2);
    chk("silent spacing", nd_stamp[base + 1] - nd_stamp[base], 16);

    // flush mid-tone with two queued entries and a colliding request
    base = nd_cnt;
    push_one(22'd4, 29'd100, 3'd7);
    push_one(22'd1, 29'd5, 3'd1);
    push_one(22'd1, 29'd5, 3'd1);
    @(negedge clk);
    chk("pre-flush busy", busy, 1);
    chk("pre-flush sample", sample_out, 16'hC000);
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_div = 22'd2; req_dur = 29'd8; req_vol = 3'd7;
    @(negedge clk);
    chk("flush req_ready", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post-flush busy", busy, 0);
    chk("post-flush sample", sample_out, 0);
    chk("post-flush ready", req_ready, 1);
    chk("post-flush done", note_done, 0);
    nz = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (busy) nz++;
    end
    chk("flush queue dropped", nz, 0);
    chk("flush no pulses", nd_cnt - base, 0);
    @(posedge clk); #1;

    // serializer framing with sample held at 16'h4000
    push_one(22'd3000, 29'd20000, 3'd7);
    found = 1'b0; c = 0;
    while (!found && c < 5000) begin
      @(negedge clk); c++;
      if (sample_out == 16'h4000) found = 1'b1;
    end
    chk("tone high seen", found, 1);
    wait_lrck(1'b0);
    wait_lrck(1'b1);
    wait_lrck(1'b0);
    for (int n = 0; n <= 520; n++) begin
      if (n % 16 == 8) bits[n / 16] = audio_sdin;
      if (n == 256) chk("lrck high mid frame", audio_lrck, 1);
      if (n < 520) @(negedge clk);
    end
    left = '0; right = '0;
    for (int s = 1; s <= 16; s++) left = {left[14:0], bits[s]};
    for (int s = 17; s <= 31; s++) right = {right[13:0], bits[s]};
    chk("i2s slot0", bits[0], 0);
    chk("i2s left word", left, 16'h4000);
    chk("i2s right bits", right, 15'h2000);
    chk("i2s next slot0", bits[32], 0);
    chk("sample held", sample_out, 16'h4000);

    // asynchronous reset mid-note
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst sample", sample_out, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst ready", req_ready, 1);
    chk("mid rst sdin", audio_sdin, 0);
    chk("mid rst lrck", audio_lrck, 0);
    #10 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("post rst lrck low", audio_lrck, 0);
    chk("post rst idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
